// File: rtl/snowbro2_snd_bus.sv
// Sound-CPU write bus for the Snow Bros 2 YM2151/OKI pair: a 4-deep write FIFO drained by a strobe sequencer.
// Optional macro SNOWBRO2_SNDBUS_BUSY_EN models the YM2151 busy interval after data writes.
module snowbro2_snd_bus (
    input  logic       CLK96,
    input  logic       RESET96,
    input  logic       YM2151_CEN,
    input  logic       OKI_CEN,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    input  logic [1:0] cpu_addr,
    input  logic [7:0] cpu_din,
    output logic       cpu_rdy,
    output logic [7:0] cpu_dout,
    output logic       cpu_dvalid,
    output logic       YM2151_CS,
    output logic       YM2151_WE,
    output logic       YM2151_WR_CMD,
    output logic [7:0] YM2151_DIN,
    input  logic [7:0] YM2151_DOUT,
    output logic       OKI_WE,
    output logic [7:0] OKI_DIN,
    input  logic [7:0] OKI_DOUT,
    output logic       OKI_BANK
);

    typedef enum logic [2:0] {StIdle, StYmStb, StOkiStb, StGap, StBusy} state_e;

    state_e     state_q;
    logic [9:0] fifo_q [4];
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0] count_q, count_d;
    logic       rdy_q;
    logic       push, pop;
    logic [1:0] head_addr;
    logic [7:0] head_data;
    logic       ym_cs_q, ym_we_q, ym_cmd_q, oki_we_q, bank_q, gap_q;
    logic [7:0] ym_din_q, oki_din_q, dout_q, rd_data;
    logic       dvalid_q;
`ifdef SNOWBRO2_SNDBUS_BUSY_EN
    logic [6:0] busy_cnt_q;
`endif

    assign push      = cpu_wr & rdy_q;
    assign pop       = (state_q == StIdle) && (count_q != 3'd0);
    assign head_addr = fifo_q[rd_ptr_q][9:8];
    assign head_data = fifo_q[rd_ptr_q][7:0];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 3'd1;
        end else if (pop && !push) begin
            count_d = count_q - 3'd1;
        end
    end

    // Storage is left unreset; count_q alone decides what is valid.
    always_ff @(posedge CLK96) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {cpu_addr, cpu_din};
        end
    end

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            rdy_q    <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_d;
            rdy_q   <= (count_d < 3'd4);
        end
    end

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            state_q   <= StIdle;
            ym_cs_q   <= 1'b0;
            ym_we_q   <= 1'b1;
            ym_cmd_q  <= 1'b0;
            ym_din_q  <= 8'h00;
            oki_we_q  <= 1'b1;
            oki_din_q <= 8'h00;
            bank_q    <= 1'b0;
            gap_q     <= 1'b0;
`ifdef SNOWBRO2_SNDBUS_BUSY_EN
            busy_cnt_q <= 7'd0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        case (head_addr)
                            2'd0, 2'd1: begin
                                ym_cs_q  <= 1'b1;
                                ym_we_q  <= 1'b0;
                                ym_cmd_q <= head_addr[0];
                                ym_din_q <= head_data;
                                state_q  <= StYmStb;
                            end
                            2'd2: begin
                                oki_we_q  <= 1'b0;
                                oki_din_q <= head_data;
                                state_q   <= StOkiStb;
                            end
                            default: begin
                                bank_q  <= head_data[0];
                                gap_q   <= 1'b0;
                                state_q <= StGap;
                            end
                        endcase
                    end
                end
                StYmStb: begin
                    if (YM2151_CEN) begin
                        ym_cs_q <= 1'b0;
                        ym_we_q <= 1'b1;
                        gap_q   <= 1'b0;
`ifdef SNOWBRO2_SNDBUS_BUSY_EN
                        busy_cnt_q <= 7'd0;
`endif
                        state_q <= ym_cmd_q ? StBusy : StGap;
                    end
                end
                StOkiStb: begin
                    if (OKI_CEN) begin
                        oki_we_q <= 1'b1;
                        gap_q    <= 1'b0;
                        state_q  <= StGap;
                    end
                end
                StGap: begin
                    gap_q <= !gap_q;
                    if (gap_q) state_q <= StIdle;
                end
                StBusy: begin
`ifdef SNOWBRO2_SNDBUS_BUSY_EN
                    if (YM2151_CEN) begin
                        busy_cnt_q <= busy_cnt_q + 7'd1;
                        if (busy_cnt_q == 7'd67) state_q <= StIdle;
                    end
`else
                    gap_q <= !gap_q;
                    if (gap_q) state_q <= StIdle;
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (cpu_addr)
            2'd0, 2'd1: begin
                rd_data = YM2151_DOUT;
`ifdef SNOWBRO2_SNDBUS_BUSY_EN
                if (state_q == StBusy) rd_data[7] = 1'b1;
`endif
            end
            2'd2:    rd_data = OKI_DOUT;
            default: rd_data = {7'b0, bank_q};
        endcase
    end

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            dvalid_q <= 1'b0;
            dout_q   <= 8'h00;
        end else begin
            dvalid_q <= cpu_rd;
            if (cpu_rd) dout_q <= rd_data;
        end
    end

    assign cpu_rdy       = rdy_q;
    assign cpu_dout      = dout_q;
    assign cpu_dvalid    = dvalid_q;
    assign YM2151_CS     = ym_cs_q;
    assign YM2151_WE     = ym_we_q;
    assign YM2151_WR_CMD = ym_cmd_q;
    assign YM2151_DIN    = ym_din_q;
    assign OKI_WE        = oki_we_q;
    assign OKI_DIN       = oki_din_q;
    assign OKI_BANK      = bank_q;

endmodule

// File: tb/tb_snowbro2_snd_bus.sv
// Directed self-checking bench for snowbro2_snd_bus; inputs driven and outputs sampled 1 ns after each rising edge.
module tb_snowbro2_snd_bus;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ym_cen = 1'b0, oki_cen = 1'b0;
    logic       wr = 1'b0, rd = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] din = 8'h00, ym_dout = 8'h00, oki_dout = 8'h00;
    logic       rdy, dvalid, ym_cs, ym_we, ym_cmd, oki_we, oki_bank;
    logic [7:0] dout, ym_din, oki_din;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    snowbro2_snd_bus dut (
        .CLK96        (clk),
        .RESET96      (rst),
        .YM2151_CEN   (ym_cen),
        .OKI_CEN      (oki_cen),
        .cpu_wr       (wr),
        .cpu_rd       (rd),
        .cpu_addr     (addr),
        .cpu_din      (din),
        .cpu_rdy      (rdy),
        .cpu_dout     (dout),
        .cpu_dvalid   (dvalid),
        .YM2151_CS    (ym_cs),
        .YM2151_WE    (ym_we),
        .YM2151_WR_CMD(ym_cmd),
        .YM2151_DIN   (ym_din),
        .YM2151_DOUT  (ym_dout),
        .OKI_WE       (oki_we),
        .OKI_DIN      (oki_din),
        .OKI_DOUT     (oki_dout),
        .OKI_BANK     (oki_bank)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [1:0] a, input logic [7:0] d);
        wr = 1'b1; addr = a; din = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic wait_cs();
        for (int i = 0; i < 20 && !ym_cs; i++) tick();
        check("ym_cs_rise", ym_cs, 1'b1);
    endtask

    task automatic ym_pulse();
        ym_cen = 1'b1;
        tick();
        ym_cen = 1'b0;
    endtask

    initial begin
        int highs;
        int pulses;

        // Reset state
        repeat (3) tick();
        check("rst_rdy", rdy, 1'b1);
        check("rst_dvalid", dvalid, 1'b0);
        check("rst_dout", dout, 8'h00);
        check("rst_ym_cs", ym_cs, 1'b0);
        check("rst_ym_we", ym_we, 1'b1);
        check("rst_ym_cmd", ym_cmd, 1'b0);
        check("rst_ym_din", ym_din, 8'h00);
        check("rst_oki_we", oki_we, 1'b1);
        check("rst_oki_din", oki_din, 8'h00);
        check("rst_bank", oki_bank, 1'b0);
        rst = 1'b0;
        tick();

        // YM address write: strobe from N+2 through the CEN cycle, then released
        put(2'd0, 8'h28);
        check("ym_addr_n1_cs", ym_cs, 1'b0);
        tick();
        check("ym_addr_cs", ym_cs, 1'b1);
        check("ym_addr_we", ym_we, 1'b0);
        check("ym_addr_cmd", ym_cmd, 1'b0);
        check("ym_addr_din", ym_din, 8'h28);
        repeat (3) tick();
        check("ym_addr_hold", ym_cs, 1'b1);
        ym_cen = 1'b1;
        check("ym_addr_cen_cycle", ym_cs, 1'b1);
        tick();
        ym_cen = 1'b0;
        check("ym_addr_rel_cs", ym_cs, 1'b0);
        check("ym_addr_rel_we", ym_we, 1'b1);
        check("ym_din_hold", ym_din, 8'h28);
        repeat (3) tick();

        // YM data write followed by address write: BUSY spacing
        put(2'd1, 8'h5A);
        put(2'd0, 8'h10);
        check("ym_data_cs", ym_cs, 1'b1);
        check("ym_data_cmd", ym_cmd, 1'b1);
        check("ym_data_din", ym_din, 8'h5A);
        ym_pulse();
        check("busy_cs", ym_cs, 1'b0);
        rd = 1'b1; addr = 2'd1; ym_dout = 8'h05;
        tick();
        rd = 1'b0;
        check("busy_rd_valid", dvalid, 1'b1);
`ifdef SNOWBRO2_SNDBUS_BUSY_EN
        check("busy_rd_dout", dout, 8'h85);
        pulses = 0;
        for (int i = 0; i < 400 && !ym_cs; i++) begin
            ym_cen = (i % 2 == 0);
            if (ym_cen) pulses++;
            tick();
        end
        ym_cen = 1'b0;
        check("busy_pulses", pulses[15:0], 16'd68);
        check("busy_next_cs", ym_cs, 1'b1);
`else
        check("busy_rd_dout", dout, 8'h05);
        check("busy_c2_cs", ym_cs, 1'b0);
        tick();
        check("busy_c3_cs", ym_cs, 1'b0);
        tick();
        check("busy_next_cs", ym_cs, 1'b1);
`endif
        check("busy_next_din", ym_din, 8'h10);
        check("busy_next_cmd", ym_cmd, 1'b0);
        ym_pulse();
        repeat (3) tick();

        // Six back-to-back writes, no CEN: the sixth finds the FIFO full
        for (int k = 1; k <= 6; k++) begin
            check("full_rdy", rdy, (k < 6) ? 1'b1 : 1'b0);
            wr = 1'b1; addr = 2'd0; din = 8'(k);
            tick();
        end
        wr = 1'b0;
        check("full_rdy_after", rdy, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            wait_cs();
            check("drain_din", ym_din, 16'(k));
            ym_pulse();
        end
        highs = 0;
        for (int i = 0; i < 12; i++) begin
            if (ym_cs) highs++;
            ym_cen = (i % 3 == 0);
            tick();
        end
        ym_cen = 1'b0;
        check("dropped_never", highs[15:0], 16'd0);
        check("drain_rdy", rdy, 1'b1);

        // OKI bank then OKI data
        put(2'd3, 8'h01);
        put(2'd2, 8'h80);
        check("bank_set", oki_bank, 1'b1);
        check("bank_no_we", oki_we, 1'b1);
        repeat (3) tick();
        check("oki_we", oki_we, 1'b0);
        check("oki_din", oki_din, 8'h80);
        rd = 1'b1; addr = 2'd3;
        tick();
        rd = 1'b0;
        check("bank_rd_valid", dvalid, 1'b1);
        check("bank_rd_dout", dout, 8'h01);
        check("oki_we_hold", oki_we, 1'b0);
        oki_cen = 1'b1;
        tick();
        oki_cen = 1'b0;
        check("oki_we_rel", oki_we, 1'b1);
        check("oki_din_hold", oki_din, 8'h80);
        repeat (3) tick();

        // Simultaneous read and write
        wr = 1'b1; rd = 1'b1; addr = 2'd2; din = 8'h33; oki_dout = 8'h0F;
        tick();
        wr = 1'b0; rd = 1'b0;
        check("rdwr_valid", dvalid, 1'b1);
        check("rdwr_dout", dout, 8'h0F);
        tick();
        check("rdwr_valid_pulse", dvalid, 1'b0);
        check("rdwr_oki_we", oki_we, 1'b0);
        check("rdwr_oki_din", oki_din, 8'h33);
        oki_cen = 1'b1;
        tick();
        oki_cen = 1'b0;
        repeat (3) tick();

        // Reset during YM strobe with three entries queued
        put(2'd0, 8'hA1);
        put(2'd0, 8'hA2);
        put(2'd0, 8'hA3);
        put(2'd0, 8'hA4);
        check("pre_rst_cs", ym_cs, 1'b1);
        check("pre_rst_din", ym_din, 8'hA1);
        rst = 1'b1;
        tick();
        check("mid_rst_cs", ym_cs, 1'b0);
        check("mid_rst_we", ym_we, 1'b1);
        check("mid_rst_rdy", rdy, 1'b1);
        check("mid_rst_din", ym_din, 8'h00);
        rst = 1'b0;
        highs = 0;
        for (int i = 0; i < 30; i++) begin
            if (ym_cs || !oki_we) highs++;
            ym_cen = (i % 3 == 0);
            tick();
        end
        ym_cen = 1'b0;
        check("post_rst_quiet", highs[15:0], 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
